// File: rtl/top_level_types.sv
// rtl/top_level_types.sv - shared core/memory interface types and memory FSM phases
package top_level_types;

  typedef enum logic [2:0] {
    mt_b  = 3'd0,
    mt_h  = 3'd1,
    mt_w  = 3'd2,
    mt_bu = 3'd3,
    mt_hu = 3'd4
  } ME_MaskType;

  typedef enum logic {
    me_rd = 1'b0,
    me_wr = 1'b1
  } ME_AccessType;

  typedef struct packed {
    logic [31:0]  addrin;
    logic [31:0]  datain;
    ME_MaskType   mask;
    ME_AccessType req;
  } CUtoME_IF;

  typedef struct packed {
    logic [31:0] loadeddata;
  } MEtoCU_IF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } MemPhases;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte/half lane extraction for loads and lane merge for stores
module mem_lane_align
  import top_level_types::*;
(
  input  logic [31:0] word_in,
  input  logic [31:0] datain,
  input  logic [1:0]  addr_lo,
  input  ME_MaskType  mask,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halves use only addr_lo[1], so misaligned halves land on the aligned lane.
  always_comb begin
    byte_sel   = word_in[{addr_lo, 3'b000} +: 8];
    half_sel   = addr_lo[1] ? word_in[31:16] : word_in[15:0];
    load_data  = word_in;
    store_word = datain;
    case (mask)
      mt_b:    load_data = {{24{byte_sel[7]}}, byte_sel};
      mt_bu:   load_data = {24'd0, byte_sel};
      mt_h:    load_data = {{16{half_sel[15]}}, half_sel};
      mt_hu:   load_data = {16'd0, half_sel};
      default: load_data = word_in;
    endcase
    case (mask)
      mt_b, mt_bu: begin
        store_word = word_in;
        store_word[{addr_lo, 3'b000} +: 8] = datain[7:0];
      end
      mt_h, mt_hu: begin
        store_word = word_in;
        if (addr_lo[1]) store_word[31:16] = datain[15:0];
        else            store_word[15:0]  = datain[15:0];
      end
      default: store_word = datain;
    endcase
  end

endmodule

// File: rtl/memory_unit.sv
// rtl/memory_unit.sv - word memory with fixed access latency; MEMORY_UNIT_MISALIGN_CHECK_EN enables alignment errors
module memory_unit
  import top_level_types::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  CUtoME_IF req_in,
  input  logic     req_in_notify,
  output logic     req_in_sync,
  output MEtoCU_IF resp_out,
  input  logic     resp_out_notify,
  output logic     resp_out_sync,
  output logic     err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  MemPhases    state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  CUtoME_IF    req_q, req_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [31:0] rd_word, load_data, store_word;
  logic        misaligned, mem_we;
  logic        unused_addr_bits;

  assign idx              = req_q.addrin[AW+1:2];
  assign rd_word          = mem[idx];
  assign unused_addr_bits = ^req_q.addrin[31:AW+2];

  mem_lane_align u_lane (
    .word_in   (rd_word),
    .datain    (req_q.datain),
    .addr_lo   (req_q.addrin[1:0]),
    .mask      (req_q.mask),
    .load_data (load_data),
    .store_word(store_word)
  );

`ifdef MEMORY_UNIT_MISALIGN_CHECK_EN
  always_comb begin
    case (req_q.mask)
      mt_b, mt_bu: misaligned = 1'b0;
      mt_h, mt_hu: misaligned = req_q.addrin[0];
      default:     misaligned = |req_q.addrin[1:0];
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    req_d   = req_q;
    data_d  = data_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_in_notify) begin
          req_d   = req_in;
          wait_d  = 4'(WAIT_CYCLES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (wait_q == 4'd0) begin
          state_d = RESP;
          err_d   = misaligned;
          data_d  = (req_q.req == me_rd && !misaligned) ? load_data : 32'd0;
          // Gate with rst so an abandoned access can never commit.
          mem_we  = (req_q.req == me_wr) && !misaligned && !rst;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_out_notify) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= 4'd0;
      req_q   <= '0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      req_q   <= req_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= store_word;
  end

  assign req_in_sync         = (state_q == IDLE);
  assign resp_out_sync       = (state_q == RESP);
  assign resp_out.loadeddata = data_q;
  assign err                 = err_q;

endmodule
